hazard_unit_sb: RTL and testbench

Parametrised successor to the 5-stage MIPS hazard unit. Keeps EX/ID forwarding and the load-use and branch stalls, now with register-0 protection on every comparison. Adds a scoreboard counter for a multi-cycle multiply/divide unit (HI/LO interlock), a decode flush for taken branches, and a saturating stall-cycle performance counter. Sits beside the pipeline datapath and drives its stall, flush and forward-select lines.

---
 rtl/hazard_unit_sb_pkg.sv | 15 +
 rtl/hazard_unit_sb_if.sv | 36 +++
 rtl/hazard_unit_sb_md_scoreboard.sv | 28 ++
 rtl/hazard_unit_sb.sv | 86 ++++++++
 tb/tb_hazard_unit_sb.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_unit_sb_pkg.sv
// Shared constants for the hazard unit: forward-select encodings,
// the hard-wired zero register and default timing parameters.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int REG_ZERO = 0;

  localparam int MD_LATENCY_DEF = 4;
  localparam int REG_AW_DEF     = 5;
  localparam int CNT_W_DEF      = 16;

endpackage

// File: rtl/hazard_unit_sb_if.sv
// Pipeline <-> hazard unit signal bundle. The pipeline (master) drives
// register/stage information; the hazard unit (slave) drives stall,
// flush and forward-select lines back.
interface hazard_unit_sb_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] RsD, RtD, RsE, RtE;
  logic [REG_AW-1:0] WriteRegE, WriteRegM, WriteRegW;
  logic              RegWriteE, RegWriteM, RegWriteW;
  logic              MemtoRegE, MemtoRegM;
  logic              BranchD, PCSrcD;
  logic              MdStartE, MdUseD;

  logic              StallF, StallD, FlushE, FlushD;
  logic              ForwardAD, ForwardBD;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              MdBusy;
  logic [CNT_W-1:0]  StallCount;

  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, PCSrcD, MdStartE, MdUseD,
    input  StallF, StallD, FlushE, FlushD, ForwardAD, ForwardBD,
           ForwardAE, ForwardBE, MdBusy, StallCount
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, PCSrcD, MdStartE, MdUseD,
    output StallF, StallD, FlushE, FlushD, ForwardAD, ForwardBD,
           ForwardAE, ForwardBE, MdBusy, StallCount
  );
endinterface

// File: rtl/hazard_unit_sb_md_scoreboard.sv
// HI/LO scoreboard for the multi-cycle multiply/divide unit. A new
// mult/div in E (re)loads the countdown; HI/LO is busy while the
// countdown is non-zero or an op is issuing this cycle.
module md_scoreboard #(
  parameter int MD_LATENCY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  output logic md_busy
);
  localparam int CW = $clog2(MD_LATENCY + 1);

  logic [CW-1:0] mdcnt;

  // Countdown: restart wins over decrement so a newer op supersedes.
  always_ff @(posedge clk) begin
    if (reset)
      mdcnt <= '0;
    else if (md_start)
      mdcnt <= CW'(MD_LATENCY);
    else if (mdcnt != '0)
      mdcnt <= mdcnt - CW'(1);
  end

  assign md_busy = md_start | (mdcnt != '0);

endmodule

// File: rtl/hazard_unit_sb.sv
// Hazard unit for the 5-stage pipeline: EX/ID forwarding, load-use,
// branch and HI/LO stalls, taken-branch decode flush, and a saturating
// stalled-cycle counter. Register 0 never forwards or causes a stall.
module hazard_unit_sb
  import hazard_pkg::*;
#(
  parameter int REG_AW     = REG_AW_DEF,
  parameter int MD_LATENCY = MD_LATENCY_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  hazard_unit_sb_if.slave    hz
);
  localparam logic [REG_AW-1:0] RZ = REG_AW'(REG_ZERO);

  logic             lwstall, branchstall, mdstall, stall;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt;

  // A producer matches a source only when it writes and the source is not r0.
  function automatic logic reg_hit(input logic [REG_AW-1:0] src,
                                   input logic [REG_AW-1:0] dst,
                                   input logic              we);
    return we && (src != RZ) && (src == dst);
  endfunction

  // Memory stage has priority over writeback for execute forwarding.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
    if (reg_hit(src, hz.WriteRegM, hz.RegWriteM))
      return FWD_MEM;
    else if (reg_hit(src, hz.WriteRegW, hz.RegWriteW))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  // Saturating increment: the counter sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  md_scoreboard #(.MD_LATENCY(MD_LATENCY)) u_md (
    .clk      (clk),
    .reset    (reset),
    .md_start (hz.MdStartE),
    .md_busy  (md_busy)
  );

  // Forwarding selects and stall causes; a stalled branch keeps its successor.
  always_comb begin
    hz.ForwardAE = fwd_sel(hz.RsE);
    hz.ForwardBE = fwd_sel(hz.RtE);
    hz.ForwardAD = reg_hit(hz.RsD, hz.WriteRegM, hz.RegWriteM);
    hz.ForwardBD = reg_hit(hz.RtD, hz.WriteRegM, hz.RegWriteM);

    lwstall = reg_hit(hz.RsD, hz.RtE, hz.MemtoRegE) |
              reg_hit(hz.RtD, hz.RtE, hz.MemtoRegE);

    branchstall = hz.BranchD &
                  (reg_hit(hz.RsD, hz.WriteRegE, hz.RegWriteE) |
                   reg_hit(hz.RtD, hz.WriteRegE, hz.RegWriteE) |
                   reg_hit(hz.RsD, hz.WriteRegM, hz.MemtoRegM) |
                   reg_hit(hz.RtD, hz.WriteRegM, hz.MemtoRegM));

    mdstall = hz.MdUseD & md_busy;
    stall   = lwstall | branchstall | mdstall;

    hz.StallF = stall;
    hz.StallD = stall;
    hz.FlushE = stall;
    hz.FlushD = hz.PCSrcD & ~stall;
    hz.MdBusy = md_busy;
  end

  // Stalled-cycle counter; coincident stall causes count once.
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (stall)
      stall_cnt <= sat_inc(stall_cnt);
  end

  assign hz.StallCount = stall_cnt;

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Bench for hazard_unit_sb: a directed table, hand-written multi-cycle
// sequences and randomized traffic, all checked against a behavioural
// model. Two instances share stimulus: 16-bit and 4-bit stall counters.
module tb_hazard_unit_sb;
  localparam int MD_LAT = 4;

  typedef struct packed {
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic BranchD, PCSrcD, MdStartE, MdUseD;
  } in_t;

  typedef struct packed {
    in_t         i;
    logic [10:0] e;
  } vec_t;

  logic clk;
  logic reset;
  in_t  cur;

  hazard_unit_sb_if #(.REG_AW(5), .CNT_W(16)) hz16 ();
  hazard_unit_sb_if #(.REG_AW(5), .CNT_W(4))  hz4 ();

  hazard_unit_sb #(.REG_AW(5), .MD_LATENCY(MD_LAT), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .hz(hz16.slave));
  hazard_unit_sb #(.REG_AW(5), .MD_LATENCY(MD_LAT), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .hz(hz4.slave));

  assign hz16.RsD = cur.RsD;             assign hz4.RsD = cur.RsD;
  assign hz16.RtD = cur.RtD;             assign hz4.RtD = cur.RtD;
  assign hz16.RsE = cur.RsE;             assign hz4.RsE = cur.RsE;
  assign hz16.RtE = cur.RtE;             assign hz4.RtE = cur.RtE;
  assign hz16.WriteRegE = cur.WriteRegE; assign hz4.WriteRegE = cur.WriteRegE;
  assign hz16.WriteRegM = cur.WriteRegM; assign hz4.WriteRegM = cur.WriteRegM;
  assign hz16.WriteRegW = cur.WriteRegW; assign hz4.WriteRegW = cur.WriteRegW;
  assign hz16.RegWriteE = cur.RegWriteE; assign hz4.RegWriteE = cur.RegWriteE;
  assign hz16.RegWriteM = cur.RegWriteM; assign hz4.RegWriteM = cur.RegWriteM;
  assign hz16.RegWriteW = cur.RegWriteW; assign hz4.RegWriteW = cur.RegWriteW;
  assign hz16.MemtoRegE = cur.MemtoRegE; assign hz4.MemtoRegE = cur.MemtoRegE;
  assign hz16.MemtoRegM = cur.MemtoRegM; assign hz4.MemtoRegM = cur.MemtoRegM;
  assign hz16.BranchD = cur.BranchD;     assign hz4.BranchD = cur.BranchD;
  assign hz16.PCSrcD = cur.PCSrcD;       assign hz4.PCSrcD = cur.PCSrcD;
  assign hz16.MdStartE = cur.MdStartE;   assign hz4.MdStartE = cur.MdStartE;
  assign hz16.MdUseD = cur.MdUseD;       assign hz4.MdUseD = cur.MdUseD;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: cycle number, cycle of the most recent
  // mult/div issue, and an unbounded count of stalled cycles.
  int cyc        = 0;
  int last_start = -1000;
  int total      = 0;

  logic [10:0] s_vec, s_vec4;
  logic [31:0] s_c16, s_c4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [10:0] exp_v(input logic st, input logic fd, input logic fad,
                                        input logic fbd, input logic [1:0] fae,
                                        input logic [1:0] fbe);
    return {st, st, st, fd, fad, fbd, fae, fbe, 1'b0};
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] s, input in_t c);
    if (s != 0 && c.RegWriteM && s == c.WriteRegM) return 2'd2;
    if (s != 0 && c.RegWriteW && s == c.WriteRegW) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic m_busy(input in_t c);
    int age;
    age = cyc - last_start;
    return c.MdStartE || (age >= 1 && age <= MD_LAT);
  endfunction

  function automatic logic m_stall(input in_t c);
    logic lw, br, e_dep, m_dep;
    lw    = c.MemtoRegE && c.RtE != 0 && (c.RtE == c.RsD || c.RtE == c.RtD);
    e_dep = c.RegWriteE && c.WriteRegE != 0 && (c.WriteRegE == c.RsD || c.WriteRegE == c.RtD);
    m_dep = c.MemtoRegM && c.WriteRegM != 0 && (c.WriteRegM == c.RsD || c.WriteRegM == c.RtD);
    br    = c.BranchD && (e_dep || m_dep);
    return lw || br || (c.MdUseD && m_busy(c));
  endfunction

  function automatic logic [10:0] model_out(input in_t c);
    logic st;
    st = m_stall(c);
    return {st, st, st, c.PCSrcD && !st,
            c.RsD != 0 && c.RegWriteM && c.RsD == c.WriteRegM,
            c.RtD != 0 && c.RegWriteM && c.RtD == c.WriteRegM,
            m_fwd(c.RsE, c), m_fwd(c.RtE, c), m_busy(c)};
  endfunction

  function automatic logic [31:0] sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // One clock: sample and compare mid-cycle, then advance the model.
  task automatic cycle();
    logic [10:0] e;
    @(negedge clk);
    s_vec  = {hz16.StallF, hz16.StallD, hz16.FlushE, hz16.FlushD, hz16.ForwardAD,
              hz16.ForwardBD, hz16.ForwardAE, hz16.ForwardBE, hz16.MdBusy};
    s_vec4 = {hz4.StallF, hz4.StallD, hz4.FlushE, hz4.FlushD, hz4.ForwardAD,
              hz4.ForwardBD, hz4.ForwardAE, hz4.ForwardBE, hz4.MdBusy};
    s_c16  = 32'(hz16.StallCount);
    s_c4   = 32'(hz4.StallCount);
    e = model_out(cur);
    chk("outs16", 32'(s_vec), 32'(e));
    chk("outs4", 32'(s_vec4), 32'(e));
    chk("cnt16", s_c16, sat(total, 65535));
    chk("cnt4", s_c4, sat(total, 15));
    @(posedge clk);
    if (reset) begin
      last_start = -1000;
      total = 0;
    end else begin
      if (cur.MdStartE) last_start = cyc;
      if (m_stall(cur)) total++;
    end
    cyc++;
    #1;
  endtask

  vec_t tv[$];

  initial begin
    vec_t v;
    int c0;

    // Directed table: combinational rules, no mult/div activity.
    v = '0; v.i.RsE = 3; v.i.WriteRegM = 3; v.i.RegWriteM = 1; v.i.WriteRegW = 3;
    v.i.RegWriteW = 1; v.e = exp_v(0, 0, 0, 0, 2'b10, 2'b00); tv.push_back(v);
    v.i.RegWriteM = 0; v.e = exp_v(0, 0, 0, 0, 2'b01, 2'b00); tv.push_back(v);
    v.i.RegWriteM = 1; v.i.RsE = 0; v.e = exp_v(0, 0, 0, 0, 2'b00, 2'b00); tv.push_back(v);
    v = '0; v.i.RtE = 7; v.i.WriteRegW = 7; v.i.RegWriteW = 1;
    v.e = exp_v(0, 0, 0, 0, 2'b00, 2'b01); tv.push_back(v);
    v = '0; v.i.RsD = 9; v.i.RtD = 9; v.i.WriteRegM = 9; v.i.RegWriteM = 1;
    v.e = exp_v(0, 0, 1, 1, 2'b00, 2'b00); tv.push_back(v);
    v = '0; v.i.RegWriteM = 1; v.e = exp_v(0, 0, 0, 0, 2'b00, 2'b00); tv.push_back(v);
    v = '0; v.i.MemtoRegE = 1; v.i.RtE = 8; v.i.RsD = 8;
    v.e = exp_v(1, 0, 0, 0, 2'b00, 2'b00); tv.push_back(v);
    v = '0; v.i.MemtoRegE = 1; v.e = exp_v(0, 0, 0, 0, 2'b00, 2'b00); tv.push_back(v);
    v = '0; v.i.BranchD = 1; v.i.RegWriteE = 1; v.i.WriteRegE = 5; v.i.RtD = 5;
    v.i.PCSrcD = 1; v.e = exp_v(1, 0, 0, 0, 2'b00, 2'b00); tv.push_back(v);
    v = '0; v.i.BranchD = 1; v.i.PCSrcD = 1; v.e = exp_v(0, 1, 0, 0, 2'b00, 2'b00); tv.push_back(v);
    v = '0; v.i.BranchD = 1; v.i.MemtoRegM = 1; v.i.WriteRegM = 6; v.i.RsD = 6;
    v.e = exp_v(1, 0, 0, 0, 2'b00, 2'b00); tv.push_back(v);
    v = '0; v.i.BranchD = 1; v.i.RegWriteE = 1; v.e = exp_v(0, 0, 0, 0, 2'b00, 2'b00); tv.push_back(v);
    v = '0; v.i.PCSrcD = 1; v.e = exp_v(0, 1, 0, 0, 2'b00, 2'b00); tv.push_back(v);

    // Reset: two unchecked edges settle the counters, then one checked reset cycle.
    cur = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cycle();
    chk("rst_cnt16", s_c16, 32'd0);
    chk("rst_busy", 32'(s_vec[0]), 32'd0);
    reset = 1'b0;

    foreach (tv[k]) begin
      cur = tv[k].i;
      c0 = total;
      cycle();
      chk($sformatf("tab%0d", k), 32'(s_vec), 32'(tv[k].e));
    end
    chk("tab_stalls", s_c16, 32'd3);

    // Mult interlock: dependent instruction held in D from issue onward.
    cur = '0; cur.MdStartE = 1; cur.MdUseD = 1;
    c0 = -1;
    for (int k = 0; k < 7; k++) begin
      cycle();
      if (k == 0) c0 = int'(s_c16);
      cur.MdStartE = 0;
      chk($sformatf("md_stall%0d", k), 32'(s_vec[10]), 32'(k <= MD_LAT));
      chk($sformatf("md_busy%0d", k), 32'(s_vec[0]), 32'(k <= MD_LAT));
    end
    chk("md_cnt_delta", s_c16, 32'(c0 + 5));

    // Restart: a second issue two cycles later extends busy.
    cur = '0; cur.MdStartE = 1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      cur.MdStartE = (k == 1);
      chk($sformatf("rs_busy%0d", k), 32'(s_vec[0]), 32'(k <= 6));
    end

    // Reset while the scoreboard is counting.
    cur = '0; cur.MdStartE = 1; cur.MdUseD = 1;
    cycle();
    cur.MdStartE = 0; reset = 1'b1;
    cycle();
    chk("rstmid_busy_hold", 32'(s_vec[0]), 32'd1);
    reset = 1'b0;
    cycle();
    chk("rstmid_busy", 32'(s_vec[0]), 32'd0);
    chk("rstmid_cnt16", s_c16, 32'd0);
    chk("rstmid_cnt4", s_c4, 32'd0);

    // Saturation of the narrow counter under a long load-use stall.
    cur = '0; reset = 1'b1;
    cycle();
    reset = 1'b0;
    cur.MemtoRegE = 1; cur.RtE = 8; cur.RsD = 8;
    repeat (20) cycle();
    cur = '0;
    cycle();
    chk("sat_cnt4", s_c4, 32'd15);
    chk("sat_cnt16", s_c16, 32'd20);
    cycle();
    chk("sat_hold4", s_c4, 32'd15);

    // Randomized traffic over a small register set to provoke matches.
    for (int n = 0; n < 400; n++) begin
      cur.RsD = 5'($urandom_range(0, 3));  cur.RtD = 5'($urandom_range(0, 3));
      cur.RsE = 5'($urandom_range(0, 3));  cur.RtE = 5'($urandom_range(0, 3));
      cur.WriteRegE = 5'($urandom_range(0, 3));
      cur.WriteRegM = 5'($urandom_range(0, 3));
      cur.WriteRegW = 5'($urandom_range(0, 3));
      cur.RegWriteE = 1'($urandom); cur.RegWriteM = 1'($urandom);
      cur.RegWriteW = 1'($urandom); cur.MemtoRegE = 1'($urandom_range(0, 3) == 0);
      cur.MemtoRegM = 1'($urandom_range(0, 3) == 0); cur.BranchD = 1'($urandom);
      cur.PCSrcD = 1'($urandom); cur.MdStartE = 1'($urandom_range(0, 7) == 0);
      cur.MdUseD = 1'($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 39) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
